// File: rtl/multicycle_control_if.sv
// Handshake between the multicycle datapath and its controller: decoded instruction
// fields flow in, datapath steering and write enables flow out.
interface multicycle_control_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    logic [3:0] alu_control;
    logic       pc_write;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [3:0] state;
    logic       illegal_instr;

    modport master (
        output opcode, funct3, funct7, zero,
        input  alu_control, pc_write, ir_write, mem_write, reg_write, adr_src,
        input  alu_src_a, alu_src_b, result_src, state, illegal_instr
    );

    modport slave (
        input  opcode, funct3, funct7, zero,
        output alu_control, pc_write, ir_write, mem_write, reg_write, adr_src,
        output alu_src_a, alu_src_b, result_src, state, illegal_instr
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore-style main controller for a multicycle RV32 subset datapath
// (lw, sw, R-type, I-type ALU, jal, beq).
module multicycle_control (
    input logic                clk,
    input logic                rst_n,
    multicycle_control_if.slave bus
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StAluWb    = 4'd7,
        StExecuteI = 4'd8,
        StJal      = 4'd9,
        StBeq      = 4'd10
    } state_e;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpRtype = 7'b0110011;
    localparam logic [6:0] OpItype = 7'b0010011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpBeq   = 7'b1100011;

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0001;
    localparam logic [3:0] AluMul = 4'b0010;
    localparam logic [3:0] AluAnd = 4'b0011;
    localparam logic [3:0] AluOr  = 4'b0100;
    localparam logic [3:0] AluXor = 4'b0101;
    localparam logic [3:0] AluSll = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;
    localparam logic [3:0] AluSrl = 4'b1000;

    localparam logic [6:0] F7Sub = 7'b0100000;
    localparam logic [6:0] F7Mul = 7'b0000001;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARd1   = 2'b10;
    localparam logic [1:0] SrcBRd2   = 2'b00;
    localparam logic [1:0] SrcBImm   = 2'b01;
    localparam logic [1:0] SrcBFour  = 2'b10;
    localparam logic [1:0] ResAluOut = 2'b00;
    localparam logic [1:0] ResMem    = 2'b01;
    localparam logic [1:0] ResAlu    = 2'b10;

    state_e state_q, state_d;

    logic [3:0] alu_control;
    logic       pc_write;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       illegal_instr;

    // SUB/MUL are only selected by funct7 for register-register ops; immediates always add.
    function automatic logic [3:0] funct_decode(input logic [6:0] op, input logic [2:0] f3,
                                                input logic [6:0] f7);
        logic [3:0] alu;
        alu = AluAdd;
        case (f3)
            3'b000: begin
                if (op == OpRtype && f7 == F7Sub) begin
                    alu = AluSub;
                end else if (op == OpRtype && f7 == F7Mul) begin
                    alu = AluMul;
                end else begin
                    alu = AluAdd;
                end
            end
            3'b001:  alu = AluSll;
            3'b010:  alu = AluSlt;
            3'b011:  alu = AluAdd;
            3'b100:  alu = AluXor;
            3'b101:  alu = AluSrl;
            3'b110:  alu = AluOr;
            3'b111:  alu = AluAnd;
            default: alu = AluAdd;
        endcase
        return alu;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                case (bus.opcode)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRtype:         state_d = StExecuteR;
                    OpItype:         state_d = StExecuteI;
                    OpJal:           state_d = StJal;
                    OpBeq:           state_d = StBeq;
                    default:         state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = (bus.opcode == OpLoad) ? StMemRead : StMemWrite;
            StMemRead:  state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: state_d = StFetch;
            StExecuteR: state_d = StAluWb;
            StExecuteI: state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StJal:      state_d = StAluWb;
            StBeq:      state_d = StFetch;
            default:    state_d = StFetch;
        endcase
    end

    always_comb begin
        alu_control   = AluAdd;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        adr_src       = 1'b0;
        alu_src_a     = SrcAPc;
        alu_src_b     = SrcBRd2;
        result_src    = ResAluOut;
        illegal_instr = 1'b0;
        case (state_q)
            StFetch: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_a  = SrcAPc;
                alu_src_b  = SrcBFour;
                result_src = ResAlu;
            end
            StDecode: begin
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
                case (bus.opcode)
                    OpLoad, OpStore, OpRtype, OpItype, OpJal, OpBeq: illegal_instr = 1'b0;
                    default:                                         illegal_instr = 1'b1;
                endcase
            end
            StMemAdr: begin
                alu_src_a = SrcARd1;
                alu_src_b = SrcBImm;
            end
            StMemRead: begin
                result_src = ResAluOut;
                adr_src    = 1'b1;
            end
            StMemWb: begin
                result_src = ResMem;
                reg_write  = 1'b1;
            end
            StMemWrite: begin
                result_src = ResAluOut;
                adr_src    = 1'b1;
                mem_write  = 1'b1;
            end
            StExecuteR: begin
                alu_src_a   = SrcARd1;
                alu_src_b   = SrcBRd2;
                alu_control = funct_decode(bus.opcode, bus.funct3, bus.funct7);
            end
            StExecuteI: begin
                alu_src_a   = SrcARd1;
                alu_src_b   = SrcBImm;
                alu_control = funct_decode(bus.opcode, bus.funct3, bus.funct7);
            end
            StAluWb: begin
                result_src = ResAluOut;
                reg_write  = 1'b1;
            end
            StJal: begin
                alu_src_a  = SrcAOldPc;
                alu_src_b  = SrcBFour;
                result_src = ResAluOut;
                pc_write   = 1'b1;
            end
            StBeq: begin
                alu_src_a   = SrcARd1;
                alu_src_b   = SrcBRd2;
                alu_control = AluSub;
                result_src  = ResAluOut;
                pc_write    = bus.zero;
            end
            default: begin
                alu_control = AluAdd;
            end
        endcase

        // Held reset shows a quiescent fetch: steering as FETCH, every enable off.
        if (!rst_n) begin
            alu_control   = AluAdd;
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            adr_src       = 1'b0;
            alu_src_a     = SrcAPc;
            alu_src_b     = SrcBFour;
            result_src    = ResAlu;
            illegal_instr = 1'b0;
        end
    end

    assign bus.alu_control   = alu_control;
    assign bus.pc_write      = pc_write;
    assign bus.ir_write      = ir_write;
    assign bus.mem_write     = mem_write;
    assign bus.reg_write     = reg_write;
    assign bus.adr_src       = adr_src;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.result_src    = result_src;
    assign bus.illegal_instr = illegal_instr;
    assign bus.state         = rst_n ? state_q : StFetch;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none; all widths SHALL be fixed as listed.
REQ-002 clk  in  1  single clock; all state SHALL change only on its rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 opcode  in  7  instruction bits [6:0] from the instruction register.
REQ-005 funct3  in  3  instruction bits [14:12].
REQ-006 funct7  in  7  instruction bits [31:25].
REQ-007 zero  in  1  ALU result-equals-zero flag, valid in the same cycle.
REQ-008 alu_control  out  4  operation code to the ALU: ADD 0000, SUB 0001, MUL 0010, AND 0011, OR 0100, XOR 0101, SLL 0110, SLT 0111, SRL 1000.
REQ-009 pc_write, ir_write, mem_write, reg_write  out  1 each  write enables.
REQ-010 adr_src  out  1  memory address select: 0 = PC, 1 = Result.
REQ-011 alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
REQ-012 alu_src_b  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
REQ-013 result_src  out  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALUResult.
REQ-014 state  out  4  current state encoding (debug).
REQ-015 illegal_instr  out  1  one-cycle pulse on an unsupported opcode.

Function
REQ-016 The block SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10; codes 11–15 SHALL go to FETCH on the next edge.
REQ-017 All outputs SHALL be combinational from state and the instruction fields; any output not listed for a state SHALL be 0.
REQ-018 FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, ADD, result_src=10, pc_write=1; next state DECODE.
REQ-019 DECODE: alu_src_a=01, alu_src_b=01, ADD; next state selected by opcode:
- 0000011 or 0100011 → MEMADR
- 0110011 → EXECUTER
- 0010011 → EXECUTEI
- 1101111 → JAL
- 1100011 → BEQ
- any other opcode → FETCH, with illegal_instr=1 during DECODE.
REQ-020 MEMADR: alu_src_a=10, alu_src_b=01, ADD; next state MEMREAD if opcode=0000011, else MEMWRITE.
REQ-021 MEMREAD: result_src=00, adr_src=1; next state MEMWB.
REQ-022 MEMWB: result_src=01, reg_write=1; next state FETCH.
REQ-023 MEMWRITE: result_src=00, adr_src=1, mem_write=1; next state FETCH.
REQ-024 EXECUTER: alu_src_a=10, alu_src_b=00, funct decode; next state ALUWB.
REQ-025 EXECUTEI: alu_src_a=10, alu_src_b=01, funct decode; next state ALUWB.
REQ-026 ALUWB: result_src=00, reg_write=1; next state FETCH.
REQ-027 JAL: alu_src_a=01, alu_src_b=10, ADD, result_src=00, pc_write=1; next state ALUWB.
REQ-028 BEQ: alu_src_a=10, alu_src_b=00, SUB, result_src=00, pc_write=zero; next state FETCH.
REQ-029 Funct decode on funct3:
- 000 → SUB if opcode=0110011 and funct7=0100000; MUL if opcode=0110011 and funct7=0000001; otherwise ADD
- 001 → SLL; 010 → SLT; 100 → XOR; 101 → SRL; 110 → OR; 111 → AND; 011 → ADD.
REQ-030 In states that do not use funct decode, alu_control SHALL be 0000.
REQ-031 Instruction latencies SHALL be:
- lw: 5 cycles; sw, R-type, I-type, jal: 4 cycles; beq: 3 cycles
- illegal opcode: 2 cycles.

Reset
REQ-032 rst_n=0 at a rising edge SHALL load state=FETCH, overriding any transition, including mid-instruction.
REQ-033 While rst_n=0, pc_write, ir_write, mem_write, reg_write and illegal_instr SHALL be forced to 0; alu_control=0000, adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10, state=0.
REQ-034 On the first edge with rst_n=1, the block SHALL perform FETCH with its normal outputs.

Verification
REQ-035 lw (opcode 0000011): state sequence 0,1,2,3,4,0; reg_write=1 only in MEMWB, with result_src=01.
REQ-036 R-type, funct3=000, funct7=0100000: alu_control=0001 in EXECUTER; funct7=0000001 gives 0010; I-type with funct7=0100000 gives 0000.
REQ-037 beq with zero=1: pc_write=1 in BEQ with alu_control=0001; zero=0: pc_write=0; next state FETCH in both cases.
REQ-038 sw: sequence 0,1,2,5,0; mem_write=1 for exactly one cycle, with adr_src=1.
REQ-039 opcode 1111111: illegal_instr=1 for one cycle in DECODE, then FETCH; no write enable asserted in DECODE.
REQ-040 rst_n=0 asserted in MEMREAD: state=0 at the next edge, with all write enables 0 while reset is held.
